// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage,
//            with a combinational stall request to the hazard unit.
//            Optional early-out for trivial operands: define DIV_FAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_valid,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             flush,
    output logic             div_stop,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             complete
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [1:0]         r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // {partial remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   r_r;
    logic               r_q_neg;
    logic               r_r_neg;

    logic [WIDTH-1:0]   w_xmag;
    logic [WIDTH-1:0]   w_ymag;
    logic [WIDTH:0]     w_hi;
    logic [WIDTH:0]     w_diff;
    logic               w_take;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_q_next;

    always_comb begin
        w_xmag     = (div_signed && x[WIDTH-1]) ? -x : x;
        w_ymag     = (div_signed && y[WIDTH-1]) ? -y : y;
        // Upper half after the left shift, keeping the carried-out bit.
        w_hi       = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff     = w_hi - {1'b0, r_div};
        w_take     = ~w_diff[WIDTH];
        w_rem_next = w_take ? w_diff[WIDTH-1:0] : w_hi[WIDTH-1:0];
        w_q_next   = {r_acc[WIDTH-2:0], w_take};
    end

`ifdef DIV_FAST_EN
    logic             w_fast;
    logic [WIDTH-1:0] w_fast_q;
    logic [WIDTH-1:0] w_fast_s;

    // Divide-by-zero yields all-ones magnitude; |x| < |y| yields zero.
    always_comb begin
        w_fast   = (y == '0) || (w_xmag < w_ymag);
        w_fast_q = (y == '0) ? '1 : '0;
        w_fast_s = (div_signed && (x[WIDTH-1] ^ y[WIDTH-1])) ? -w_fast_q : w_fast_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_div   <= '0;
            r_s     <= '0;
            r_r     <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (flush) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (div_valid) begin
                        r_div   <= w_ymag;
                        r_acc   <= {{WIDTH{1'b0}}, w_xmag};
                        r_cnt   <= '0;
                        r_q_neg <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        r_r_neg <= div_signed & x[WIDTH-1];
`ifdef DIV_FAST_EN
                        if (w_fast) begin
                            r_state <= c_DONE;
                            r_s     <= w_fast_s;
                            r_r     <= x;
                        end else begin
                            r_state <= c_BUSY;
                        end
`else
                        r_state <= c_BUSY;
`endif
                    end
                end
                c_BUSY: begin
                    r_acc <= {w_rem_next, w_q_next};
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                        r_s     <= r_q_neg ? -w_q_next : w_q_next;
                        r_r     <= r_r_neg ? -w_rem_next : w_rem_next;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign complete = (r_state == c_DONE);
    assign div_stop = resetn & div_valid & ~complete & ~flush;
    assign s        = r_s;
    assign r        = r_r;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : Self-checking bench for div_iter (directed + random ops, queue scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_valid;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic        flush;
    logic        div_stop;
    logic [31:0] s;
    logic [31:0] r;
    logic        complete;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    div_iter #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_valid  (div_valid),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .flush      (flush),
        .div_stop   (div_stop),
        .s          (s),
        .r          (r),
        .complete   (complete)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic sg, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_EN
        logic [31:0] am;
        logic [31:0] bm;
        am = (sg && a[31]) ? -a : a;
        bm = (sg && b[31]) ? -b : b;
        if (b == 32'd0 || am < bm) return 1;
`endif
        return 33;
    endfunction

    // Called at a negedge; drives the op as cycle 0 and returns at the
    // negedge of the completion cycle with div_valid still high.
    task automatic run_op(input string tag, input logic sg, input logic [31:0] xa,
                          input logic [31:0] ya, input logic [31:0] es, input logic [31:0] er);
        int          cyc;
        int          lat;
        logic [63:0] e;
        lat = lat_of(sg, xa, ya);
        sb_q.push_back({es, er});
        div_valid  = 1'b1;
        div_signed = sg;
        x          = xa;
        y          = ya;
        cyc        = 0;
        forever begin
            #1;
            if (complete === 1'b1 || cyc >= lat + 5) break;
            chk({tag, "_stop"}, {63'd0, div_stop}, 64'd1);
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_complete"}, {63'd0, complete}, 64'd1);
        chk({tag, "_stop_done"}, {63'd0, div_stop}, 64'd0);
        e = sb_q.pop_front();
        chk({tag, "_s"}, {32'd0, s}, {32'd0, e[63:32]});
        chk({tag, "_r"}, {32'd0, r}, {32'd0, e[31:0]});
    endtask

    initial begin
        logic        saw_complete;
        logic [31:0] rx;
        logic [31:0] ry;
        logic [31:0] qs;
        logic [31:0] rs;

        resetn     = 1'b0;
        div_valid  = 1'b1;
        div_signed = 1'b0;
        x          = 32'd100;
        y          = 32'd7;
        flush      = 1'b0;

        // Reset state, with div_valid high to show div_stop is forced low
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stop", {63'd0, div_stop}, 64'd0);
        chk("rst_complete", {63'd0, complete}, 64'd0);
        chk("rst_s", {32'd0, s}, 64'd0);
        chk("rst_r", {32'd0, r}, 64'd0);
        @(negedge clk);
        resetn    = 1'b1;
        div_valid = 1'b0;
        @(negedge clk);

        // Basic DIVU, then complete must drop
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        @(negedge clk);
        div_valid = 1'b0;
        #1;
        chk("divu_100_7_complete_low", {63'd0, complete}, 64'd0);
        chk("hold_s", {32'd0, s}, 64'd14);
        chk("hold_r", {32'd0, r}, 64'd2);

        // Signed directed cases
        @(negedge clk);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        @(negedge clk); div_valid = 1'b0; @(negedge clk);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        @(negedge clk); div_valid = 1'b0; @(negedge clk);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        @(negedge clk); div_valid = 1'b0; @(negedge clk);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        @(negedge clk); div_valid = 1'b0; @(negedge clk);
        run_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB);
        @(negedge clk); div_valid = 1'b0; @(negedge clk);
        run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3);
        @(negedge clk); div_valid = 1'b0; @(negedge clk);

        // Flush at cycle 10, new op at cycle 12
        div_valid  = 1'b1;
        div_signed = 1'b0;
        x          = 32'd100;
        y          = 32'd7;
        saw_complete = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (complete === 1'b1) saw_complete = 1'b1;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_stop", {63'd0, div_stop}, 64'd0);
        @(negedge clk);
        flush     = 1'b0;
        div_valid = 1'b0;
        #1;
        if (complete === 1'b1) saw_complete = 1'b1;
        chk("flush_no_complete", {63'd0, saw_complete}, 64'd0);
        chk("flush_hold_r", {32'd0, r}, 64'd3);
        @(negedge clk);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Back-to-back: div_valid stays high through DONE into the next op
        @(negedge clk);
        run_op("b2b_first", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        @(negedge clk);
        run_op("b2b_second", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);
        @(negedge clk); div_valid = 1'b0; @(negedge clk);

        // Random operands checked against the language's own division
        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            ry = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (ry == 32'd0) ry = 32'd1;
            if (i % 2 == 1) begin
                if (rx == 32'h8000_0000 && ry == 32'hFFFF_FFFF) ry = 32'd3;
                qs = $signed(rx) / $signed(ry);
                rs = $signed(rx) % $signed(ry);
                run_op("rand_div", 1'b1, rx, ry, qs, rs);
            end else begin
                qs = rx / ry;
                rs = rx % ry;
                run_op("rand_divu", 1'b0, rx, ry, qs, rs);
            end
            @(negedge clk); div_valid = 1'b0; @(negedge clk);
        end

        // Reset mid-operation at cycle 5
        div_valid  = 1'b1;
        div_signed = 1'b0;
        x          = 32'd100;
        y          = 32'd7;
        for (int c = 1; c < 5; c++) @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_stop", {63'd0, div_stop}, 64'd0);
        @(negedge clk);
        resetn    = 1'b1;
        div_valid = 1'b0;
        #1;
        chk("midrst_s", {32'd0, s}, 64'd0);
        chk("midrst_r", {32'd0, r}, 64'd0);
        saw_complete = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (complete === 1'b1) saw_complete = 1'b1;
        end
        chk("midrst_no_complete", {63'd0, saw_complete}, 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative 32-bit radix-2 divider for the EX stage. Executes DIV and DIVU, producing quotient and remainder for HI/LO writeback.
- Produces the `div_stop` stall request consumed by the pipeline hazard unit. That request freezes EX (stallE = 01) until the result is ready.
- Sits between EX operand muxing (after forwarding) and the HI/LO write path.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  core clock
- resetn  input  1  synchronous active-low reset
- div_valid  input  1  EX holds a valid DIV/DIVU; held high while stalled
- div_signed  input  1  1 = DIV (signed), 0 = DIVU
- x  input  WIDTH  dividend (forwarded rs)
- y  input  WIDTH  divisor (forwarded rt)
- flush  input  1  exception/ERET cancel of EX contents
- div_stop  output  1  stall request to hazard unit
- s  output  WIDTH  quotient (to LO)
- r  output  WIDTH  remainder (to HI)
- complete  output  1  result valid, one-cycle pulse

Behaviour:
- Reset (resetn=0 at posedge):
  - state = IDLE; s, r = 0; complete = 0; counter = 0.
  - div_stop forced to 0 while resetn = 0.
- States: IDLE, BUSY, DONE.
- IDLE: if div_valid and not flush:
  - latch |x| and |y| (magnitude when div_signed=1, raw otherwise);
  - latch quotient sign q_neg = div_signed & (x[MSB]^y[MSB]) and remainder sign r_neg = div_signed & x[MSB];
  - clear the 64-bit partial remainder/quotient register and counter; go to BUSY.
- BUSY:
  - One restoring step per cycle: shift left 1, trial-subtract the {0,|y|} 33-bit value from the upper bits.
  - If non-negative, keep the difference and set the quotient LSB; otherwise restore.
  - counter increments; after WIDTH steps (counter == WIDTH-1 on the last step) go to DONE.
  - On the final step, register s = q_neg ? -q : q and r = r_neg ? -rem : rem (two's complement, WIDTH bits).
- DONE: complete = 1 for exactly this cycle; go to IDLE unconditionally.
  - div_valid seen in the following IDLE cycle is a new instruction.
- Latency: div_valid first high at cycle 0 → complete at cycle WIDTH+1 (33).
- div_stop = div_valid & ~complete & ~flush, combinational.
  - High cycles 0..32; low in the DONE cycle so EX advances.
- s and r hold their value after DONE until the next result is registered.
- flush: from any state, next state is IDLE; complete is not asserted for the cancelled op.
  - flush has priority over a start in the same cycle.
- Reset mid-operation: same as flush plus s, r cleared.
- Divide by zero: natural restoring result.
  - Unsigned: s = all ones, r = x.
  - Signed: magnitudes q = all ones, rem = |x|, then sign correction. Example: -5/0 gives s = 0x00000001, r = 0xFFFFFFFB.
- Overflow 0x80000000 / 0xFFFFFFFF signed: s = 0x80000000, r = 0; no exception.
- Remainder sign always follows dividend; the remainder is zero or has |r| < |y| (y ≠ 0).

Optional Feature:
- Macro: DIV_FAST_EN.
- Defined: in IDLE on start, if y == 0 or |x| < |y| (unsigned magnitude compare), skip BUSY and go straight to DONE.
  - |x| < |y|: s = 0, r = x.
  - y == 0: the values stated above.
  - complete at cycle 1; div_stop high only in cycle 0.
- Not defined: every operation takes full WIDTH+1 latency; result values are identical in both builds.

Test Plan:
- DIVU x=100, y=7, div_valid held → div_stop high cycles 0–32, complete=1 at cycle 33, s=14, r=2; complete low at cycle 34.
- DIV x=0xFFFFFFF9 (-7), y=2 → s=0xFFFFFFFD, r=0xFFFFFFFF; DIV x=7, y=0xFFFFFFFE → s=0xFFFFFFFD, r=1.
- DIV x=0x80000000, y=0xFFFFFFFF → s=0x80000000, r=0. DIVU x=5, y=0 → s=0xFFFFFFFF, r=5.
- Start DIVU 100/7, assert flush at cycle 10 → no complete pulse. New DIVU 9/3 starting cycle 12 → complete at cycle 45, s=3, r=0.
- Back-to-back: DIVU 100/7 then div_valid stays high with x=50, y=5 → second complete 34 cycles after the first, s=10, r=0. resetn=0 at cycle 5 of the first op → s=r=0, complete never pulses.
- With DIV_FAST_EN: DIVU 3/10 → complete at cycle 1, s=0, r=3. Same stimulus without the macro → complete at cycle 33, same values.
